// File: rtl/regfile_scoreboard.sv
// Dual-write, dual-read register file with a per-register pending scoreboard.
// Reads bypass same-cycle writes; pend_cnt tracks how many registers await a producer.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;
    logic [ADDR_W:0]   cnt_next;

    logic we0_eff;
    logic we1_eff;
    logic iss_eff;

    // With ZERO_REG, register 0 never accepts writes or producers.
    assign we0_eff = we0 && !(ZERO_REG && (wa0 == '0));
    assign we1_eff = we1 && !(ZERO_REG && (wa1 == '0));
    assign iss_eff = iss_en && !(ZERO_REG && (iss_addr == '0));

    logic zero1, hit0_1, hit1_1;
    logic zero2, hit0_2, hit1_2;

    // NOTE: every combinational output gets a value on every path (default first) so no latch is inferred.
    always_comb begin
        zero1  = ZERO_REG && (ra1 == '0);
        hit0_1 = we0_eff && (wa0 == ra1);
        hit1_1 = we1_eff && (wa1 == ra1);
        rd1    = regs[ra1];
        if (zero1) begin
            rd1 = '0;
        end else if (hit1_1) begin
            rd1 = wd1;
        end else if (hit0_1) begin
            rd1 = wd0;
        end
        busy1 = pending[ra1] && !(hit0_1 || hit1_1) && !zero1;
    end

    always_comb begin
        zero2  = ZERO_REG && (ra2 == '0);
        hit0_2 = we0_eff && (wa0 == ra2);
        hit1_2 = we1_eff && (wa1 == ra2);
        rd2    = regs[ra2];
        if (zero2) begin
            rd2 = '0;
        end else if (hit1_2) begin
            rd2 = wd1;
        end else if (hit0_2) begin
            rd2 = wd0;
        end
        busy2 = pending[ra2] && !(hit0_2 || hit1_2) && !zero2;
    end

    // Clears first, then the set: a younger producer issued this cycle wins over a retiring write.
    always_comb begin
        pending_next = pending;
        if (we0_eff) pending_next[wa0] = 1'b0;
        if (we1_eff) pending_next[wa1] = 1'b0;
        if (iss_eff) pending_next[iss_addr] = 1'b1;
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, pending_next[i]};
        end
    end

    // NOTE: the data array is reset too, since a reset must leave every register reading zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments; port 1 is written last so it wins an address tie.
            if (we0_eff) regs[wa0] <= wd0;
            if (we1_eff) regs[wa1] <= wd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pending_next;
            pend_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: array model checked every negedge, plus hand-computed directed checks.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra1, ra2, wa0, wa1, iss_addr;
    logic [31:0] rd1, rd2, wd0, wd1;
    logic        busy1, busy2, we0, we1, iss_en;
    logic [5:0]  pend_cnt;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    logic [31:0] m_regs [32];
    logic        m_pend [32];

    regfile_scoreboard dut (
        .clk(clk), .reset(rst),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the register file is an array, the scoreboard is a set of pending addresses.
    function automatic logic written(input logic [4:0] a);
        return (we0 && wa0 == a) || (we1 && wa1 == a);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return (a != 5'd0) && m_pend[a] && !written(a);
    endfunction

    function automatic logic [5:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) if (m_pend[i]) n++;
        return 6'(n);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= 32'd0;
                m_pend[i] <= 1'b0;
            end
        end else begin
            if (we0 && wa0 != 5'd0) begin
                m_regs[wa0] <= wd0;
                m_pend[wa0] <= 1'b0;
            end
            if (we1 && wa1 != 5'd0) begin
                m_regs[wa1] <= wd1;
                m_pend[wa1] <= 1'b0;
            end
            if (iss_en && iss_addr != 5'd0) m_pend[iss_addr] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_rd1", rd1, exp_rd(ra1));
            check("model_rd2", rd2, exp_rd(ra2));
            check("model_busy1", busy1, exp_busy(ra1));
            check("model_busy2", busy2, exp_busy(ra2));
            check("model_pend_cnt", pend_cnt, exp_cnt());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_addr = '0;
    endtask

    task automatic apply(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic is, input logic [4:0] ia,
                         input logic [4:0] r1, input logic [4:0] r2);
        we0 = w0; wa0 = a0; wd0 = d0;
        we1 = w1; wa1 = a1; wd1 = d1;
        iss_en = is; iss_addr = ia;
        ra1 = r1; ra2 = r2;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ra1 = '0; ra2 = '0;
        idle();
        #2 rst = 1'b0;
        #1 cmp_en = 1'b1;

        // Reset state over every address
        tick();
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            check("rst_rd", {rd1, rd2}, 64'd0);
            check("rst_busy_cnt", {busy1, busy2, pend_cnt}, 64'd0);
        end
        tick();
        rst = 1'b1;
        tick();

        // Same-cycle bypass then storage
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5A5_A5A5; ra1 = 5'd3;
        #2 check("bypass_w0", rd1, 32'hA5A5_A5A5);
        tick(); idle();
        #1 check("stored_w0", rd1, 32'hA5A5_A5A5);

        // Both ports to one address: port 1 wins
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22; ra1 = 5'd7;
        #2 check("dual_bypass", rd1, 32'h22);
        tick(); idle();
        #1 check("dual_stored", rd1, 32'h22);

        // Scoreboard sequence
        iss_en = 1'b1; iss_addr = 5'd5; tick();
        iss_addr = 5'd9; tick(); idle();
        ra1 = 5'd5;
        #1 check("sb_cnt2", pend_cnt, 6'd2);
        check("sb_busy5", busy1, 1'b1);
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h55;
        #1 check("sb_busy5_write", busy1, 1'b0);
        tick(); idle();
        #1 check("sb_cnt1", pend_cnt, 6'd1);
        iss_en = 1'b1; iss_addr = 5'd9; we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99; ra1 = 5'd9;
        tick(); idle();
        #1 check("sb_setwins_cnt", pend_cnt, 6'd1);
        check("sb_setwins_busy", busy1, 1'b1);

        // Register zero ignores writes and issues
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; iss_en = 1'b1; iss_addr = 5'd0; ra1 = 5'd0;
        #2 check("zero_rd", rd1, 32'd0);
        check("zero_busy", busy1, 1'b0);
        tick(); idle();
        #1 check("zero_cnt", pend_cnt, 6'd1);

        // Pend 1..4 then async reset mid-cycle
        for (int i = 1; i <= 4; i++) begin
            iss_en = 1'b1; iss_addr = 5'(i);
            tick();
        end
        idle();
        ra1 = 5'd1; ra2 = 5'd3;
        #1 check("pend5_cnt", pend_cnt, 6'd5);
        #2 rst = 1'b0;
        #1 check("midrst_cnt", pend_cnt, 6'd0);
        check("midrst_busy", {busy1, busy2}, 2'b00);
        check("midrst_rd", {rd1, rd2}, 64'd0);

        // Writes during reset: bypass only, nothing stored
        tick();
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h1234; ra1 = 5'd10;
        #2 check("rst_bypass", rd1, 32'h1234);
        tick(); idle();
        rst = 1'b1;
        #1 check("rst_nostore", rd1, 32'd0);
        tick();

        // Directed mixed vectors, checked by the model each cycle
        apply(1, 5'd1,  32'h100,  1, 5'd2,  32'h200,       1, 5'd4,  5'd1,  5'd2);
        apply(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,         1, 5'd6,  5'd4,  5'd6);
        apply(1, 5'd4,  32'h444,  0, 5'd0,  32'h0,         1, 5'd5,  5'd4,  5'd5);
        apply(1, 5'd6,  32'h666,  1, 5'd6,  32'h6B6,       1, 5'd6,  5'd6,  5'd6);
        apply(1, 5'd8,  32'h1,    1, 5'd8,  32'h2,         1, 5'd0,  5'd8,  5'd0);
        apply(0, 5'd0,  32'h0,    1, 5'd31, 32'hFFFF_FFFF, 1, 5'd31, 5'd31, 5'd1);
        apply(1, 5'd5,  32'h55,   1, 5'd31, 32'h0,         0, 5'd0,  5'd5,  5'd31);
        apply(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,         1, 5'd2,  5'd2,  5'd2);
        apply(1, 5'd0,  32'hDEAD, 0, 5'd0,  32'h0,         1, 5'd0,  5'd0,  5'd6);
        apply(0, 5'd0,  32'h0,    1, 5'd2,  32'h7,         1, 5'd3,  5'd2,  5'd3);
        idle();
        ra1 = 5'd6; ra2 = 5'd2;
        #1 check("vec_cnt", pend_cnt, 6'd2);
        check("vec_busy6", busy1, 1'b1);
        check("vec_rd6", rd1, 32'h6B6);
        check("vec_rd2", rd2, 32'h7);

        tick();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
